fp_add_pipe_hs: RTL and testbench

Elastic, handshaked pipeline around the combinational `bf16_add` core: operands enter with a valid/ready handshake, traverse `PIPE_DEPTH` register stages with per-stage valid bits, and leave through a valid/ready output.
It generalises the fixed output-register retiming wrapper in several ways: backpressure, bubble collapsing, a sideband tag, a format echo, occupancy reporting and synchronous reset.
It sits between the FPU issue logic and the writeback arbiter in the bf16/fp32 add path.

---
 rtl/fp_add_pipe_hs.sv | 125 ++++++++++++
 tb/tb_fp_add_pipe_hs.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe_hs.sv
// fp_add_pipe_hs: elastic valid/ready pipeline around a combinational bf16/fp32 adder core.
// Bubbles collapse through the ready chain; tag and format travel with each operation.
package fp_add_pkg;
   typedef enum logic [0:0] {FMT_FP32 = 1'b0, FMT_BF16 = 1'b1} fp_fmt_e;
endpackage

module bf16_add
   import fp_add_pkg::*;
(
   input  fp_fmt_e     fmt,
   input  logic [31:0] X,
   input  logic [31:0] Y,
   output logic [31:0] R
);
   logic        bf, eff_sub, sgn, nan, inf, ovf, lsb, grd, stk, rup;
   logic [31:0] a, b, big, sml, r32;
   logic [30:0] rmask, rinc, packed_r;
   logic [7:0]  ea, eb, d, sh, ef;
   logic [50:0] ma, mb, mbs, s;
   logic [49:0] norm;
   logic [5:0]  lz;
   function automatic logic [5:0] clz50(input logic [49:0] v);
      clz50 = 6'd50;
      for (int i = 0; i < 50; i++) if (v[i]) clz50 = 6'(49 - i);
   endfunction
   // bf16 operands are widened to fp32 (exact) and rounded at bit 16 of the fp32 field
   always_comb begin
      bf = fmt == FMT_BF16;
      a = bf ? {X[15:0], 16'h0} : X;
      b = bf ? {Y[15:0], 16'h0} : Y;
      {big, sml} = (a[30:0] >= b[30:0]) ? {a, b} : {b, a};
      ea = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
      eb = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
      d = ea - eb;
      ma = {1'b0, big[30:23] != 8'd0, big[22:0], 26'h0};
      mb = {1'b0, sml[30:23] != 8'd0, sml[22:0], 26'h0};
      mbs = (mb >> d) | 51'(((mb >> d) << d) != mb);
      eff_sub = big[31] ^ sml[31];
      s = eff_sub ? ma - mbs : ma + mbs;
      lz = clz50(s[49:0]);
      sh = (8'(lz) < ea) ? 8'(lz) : ea - 8'd1;
      norm = s[50] ? {s[50:2], s[1] | s[0]} : 50'(s << sh);
      ef = s[50] ? ea + 8'd1 : (norm[49] ? ea - sh : 8'd0);
      ovf = s[50] && ea == 8'd254;
      rmask = bf ? 31'h7FFF_0000 : 31'h7FFF_FFFF;
      rinc = bf ? 31'h0001_0000 : 31'h1;
      lsb = bf ? norm[42] : norm[26];
      grd = bf ? norm[41] : norm[25];
      stk = bf ? |norm[40:0] : |norm[24:0];
      rup = grd & (lsb | stk);
      packed_r = ({ef, norm[48:26]} & rmask) + (rup ? rinc : 31'd0);
      sgn = (s == 51'd0 && eff_sub) ? 1'b0 : big[31];
      nan = (a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
            (a[30:0] == 31'h7F80_0000 && b[30:0] == 31'h7F80_0000 && eff_sub);
      inf = a[30:23] == 8'hFF || b[30:23] == 8'hFF || ovf;
      r32 = nan ? 32'h7FC0_0000 : inf ? {sgn, 31'h7F80_0000} : {sgn, packed_r};
      R = bf ? {16'h0, r32[31:16]} : r32;
   end
endmodule

module fp_add_pipe_hs
   import fp_add_pkg::*;
#(
   parameter int PIPE_DEPTH = 2,
   parameter int TAG_W = 4,
   localparam int OCC_W = PIPE_DEPTH > 0 ? $clog2(PIPE_DEPTH + 1) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  fp_fmt_e          fmt,
   input  logic [31:0]      X,
   input  logic [31:0]      Y,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [31:0]      R,
   output fp_fmt_e          out_fmt,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OCC_W-1:0] occupancy,
   output logic             busy
);
   localparam int DW = 32 + 1 + TAG_W;
   logic [31:0] core_r;
   bf16_add u_core (.fmt(fmt), .X(X), .Y(Y), .R(core_r));
   if (PIPE_DEPTH == 0) begin : g_comb
      assign in_ready = out_ready;
      assign out_valid = in_valid;
      assign R = core_r;
      assign out_fmt = fmt;
      assign out_tag = in_tag;
      assign occupancy = '0;
      assign busy = 1'b0;
   end else begin : g_pipe
      logic [PIPE_DEPTH-1:0] v, vin, rdy;
      logic [DW-1:0] d [PIPE_DEPTH];
      logic [DW-1:0] din [PIPE_DEPTH];
      assign vin = PIPE_DEPTH'({v, in_valid});
      // a stage accepts when it or any stage downstream of it is empty
      for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_rdy
         assign rdy[i] = out_ready | ~&v[PIPE_DEPTH-1:i];
      end
      always_comb begin
         din[0] = {core_r, fmt, in_tag};
         for (int i = 1; i < PIPE_DEPTH; i++) din[i] = d[i-1];
      end
      always_ff @(posedge clk)
         for (int i = 0; i < PIPE_DEPTH; i++)
            if (rst) begin
               v[i] <= 1'b0;
               d[i] <= '0;
            end else if (rdy[i]) begin
               v[i] <= vin[i];
               if (vin[i]) d[i] <= din[i];
            end
      assign in_ready = rdy[0];
      assign out_valid = v[PIPE_DEPTH-1];
      assign R = d[PIPE_DEPTH-1][DW-1 -: 32];
      assign out_fmt = fp_fmt_e'(d[PIPE_DEPTH-1][TAG_W]);
      assign out_tag = d[PIPE_DEPTH-1][TAG_W-1:0];
      assign occupancy = OCC_W'($countones(v));
      assign busy = |v;
   end
endmodule

// File: tb/tb_fp_add_pipe_hs.sv
// tb_fp_add_pipe_hs: scoreboard bench for fp_add_pipe_hs at depths 0, 2 and 3.
module tb_fp_add_pipe_hs;
   import fp_add_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   fp_fmt_e fmt = FMT_FP32;
   logic [31:0] x = '0, y = '0;
   logic [3:0] tag = '0;
   logic iv0 = 0, iv2 = 0, iv3 = 0, or0 = 0, or2 = 1, or3 = 1;
   logic ir0, ir2, ir3, ov0, ov2, ov3, bz0, bz2, bz3;
   logic [31:0] r0, r2, r3;
   fp_fmt_e of0, of2, of3;
   logic [3:0] ot0, ot2, ot3;
   logic [0:0] oc0;
   logic [1:0] oc2, oc3;
   logic [36:0] cur_exp, e1, ea;
   logic [36:0] q3 [$];
   int n_vec = 0, n_bad = 0;
   logic [96:0] sp [14] = '{
      {1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000},
      {1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000},
      {1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000},
      {1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
      {1'b0, 32'h00000001, 32'h00000001, 32'h00000002},
      {1'b0, 32'h80000000, 32'h80000000, 32'h80000000},
      {1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000},
      {1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000},
      {1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002},
      {1'b0, 32'h40400000, 32'hC0000000, 32'h3F800000},
      {1'b1, 32'h00003F80, 32'h00003F80, 32'h00004000},
      {1'b1, 32'h00003F80, 32'h00003B80, 32'h00003F80},
      {1'b1, 32'h0000FF80, 32'h00007F80, 32'h00007FC0},
      {1'b1, 32'h00000001, 32'h00000001, 32'h00000002}};

   always #5 clk = ~clk;

   fp_add_pipe_hs #(.PIPE_DEPTH(0), .TAG_W(4)) u0 (.clk(clk), .rst(rst), .fmt(fmt), .X(x), .Y(y),
      .in_tag(tag), .in_valid(iv0), .in_ready(ir0), .R(r0), .out_fmt(of0), .out_tag(ot0),
      .out_valid(ov0), .out_ready(or0), .occupancy(oc0), .busy(bz0));
   fp_add_pipe_hs #(.PIPE_DEPTH(2), .TAG_W(4)) u2 (.clk(clk), .rst(rst), .fmt(fmt), .X(x), .Y(y),
      .in_tag(tag), .in_valid(iv2), .in_ready(ir2), .R(r2), .out_fmt(of2), .out_tag(ot2),
      .out_valid(ov2), .out_ready(or2), .occupancy(oc2), .busy(bz2));
   fp_add_pipe_hs #(.PIPE_DEPTH(3), .TAG_W(4)) u3 (.clk(clk), .rst(rst), .fmt(fmt), .X(x), .Y(y),
      .in_tag(tag), .in_valid(iv3), .in_ready(ir3), .R(r3), .out_fmt(of3), .out_tag(ot3),
      .out_valid(ov3), .out_ready(or3), .occupancy(oc3), .busy(bz3));

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   function automatic real to_real(input logic [31:0] b);
      return $bitstoreal({b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'h0});
   endfunction

   function automatic logic [31:0] round_fp(input real v, input int fb);
      logic [63:0] q = $realtobits(v);
      logic [51:0] f = q[51:0];
      logic [51:0] rem = f & ((52'd1 << (52 - fb)) - 52'd1);
      logic [51:0] half = 52'd1 << (51 - fb);
      logic [22:0] fr = 23'(f >> (52 - fb)) << (23 - fb);
      logic [31:0] k = {q[63], 8'(int'(q[62:52]) - 896), fr};
      if (v == 0.0) return 32'h0;
      if (rem > half || (rem == half && f[52 - fb])) k = k + (32'd1 << (23 - fb));
      return k;
   endfunction

   function automatic logic [31:0] model(input logic f, input logic [31:0] a, input logic [31:0] b);
      return f ? {16'h0, 16'(round_fp(to_real({a[15:0], 16'h0}) + to_real({b[15:0], 16'h0}), 7) >> 16)}
               : round_fp(to_real(a) + to_real(b), 23);
   endfunction

   function automatic logic [31:0] rop(input logic f);
      logic [31:0] r = $urandom;
      logic [7:0] e = 8'($urandom_range(120, 135));
      return f ? {r[31:16], r[15], e, r[6:0]} : {r[31], e, r[22:0]};
   endfunction

   task automatic drv(input logic f, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                      input logic [31:0] r);
      fmt = fp_fmt_e'(f);
      x = a;
      y = b;
      tag = t;
      cur_exp = {r, f, t};
   endtask

   task automatic drv_rand(input logic f, input logic [3:0] t);
      logic [31:0] a = rop(f);
      logic [31:0] b = ($urandom_range(0, 15) == 0) ? a ^ (f ? 32'h8000 : 32'h8000_0000) : rop(f);
      drv(f, a, b, t, model(f, a, b));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk)
      if (rst) q3.delete();
      else begin
         if (iv3 && ir3) q3.push_back(cur_exp);
         if (ov3 && or3) begin
            if (q3.size() == 0) chk("sb_spurious", 64'(ov3), 64'(0));
            else chk("sb_out", {r3, of3, ot3}, q3.pop_front());
         end
      end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   initial begin
      iv2 = 1;
      iv3 = 1;
      drv(0, 32'h3F800000, 32'h3F800000, 4'd9, 32'h40000000);
      repeat (2) @(posedge clk);
      #1 rst = 0;
      iv2 = 0;
      iv3 = 0;
      @(negedge clk);
      chk("rst_out_valid", ov3, 0);
      chk("rst_occupancy", oc3, 0);
      chk("rst_busy", bz3, 0);
      chk("rst_r", r3, 0);
      chk("rst_tag", ot3, 0);
      chk("rst_in_ready", ir3, 1);
      chk("rst_out_valid2", ov2, 0);
      tick();
      iv2 = 1;
      drv(0, 32'h3F800000, 32'h3F800000, 4'd5, 32'h40000000);
      tick();
      drv(0, 32'h40000000, 32'h40000000, 4'd6, 32'h40800000);
      tick();
      iv2 = 0;
      @(negedge clk);
      chk("st_valid_a", ov2, 1);
      chk("st_r_a", r2, 32'h40000000);
      chk("st_tag_a", ot2, 5);
      chk("st_fmt_a", 64'(of2), 64'(FMT_FP32));
      tick();
      @(negedge clk);
      chk("st_valid_b", ov2, 1);
      chk("st_r_b", r2, 32'h40800000);
      chk("st_tag_b", ot2, 6);
      chk("st_fmt_b", 64'(of2), 64'(FMT_FP32));
      tick();
      @(negedge clk);
      chk("st_idle", ov2, 0);
      chk("st_busy", bz2, 0);
      tick();
      or3 = 0;
      for (int k = 0; k < 4; k++) begin
         iv3 = 1;
         drv_rand(0, 4'(k + 1));
         if (k == 0) e1 = cur_exp;
         @(negedge clk);
         chk("bp_in_ready", ir3, 64'(k < 3));
         tick();
      end
      repeat (3) begin
         @(negedge clk);
         chk("bp_occupancy", oc3, 3);
         chk("bp_in_ready_full", ir3, 0);
         chk("bp_hold", {r3, of3, ot3}, e1);
         tick();
      end
      or3 = 1;
      @(negedge clk);
      chk("bp_in_ready_release", ir3, 1);
      tick();
      iv3 = 0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_drain", ov3, 1);
         tick();
      end
      @(negedge clk);
      chk("bp_empty", ov3, 0);
      tick();
      or3 = 0;
      iv3 = 1;
      drv_rand(1, 4'hA);
      ea = cur_exp;
      @(negedge clk);
      chk("bub_in_ready_a", ir3, 1);
      tick();
      iv3 = 0;
      @(negedge clk);
      chk("bub_in_ready_idle", ir3, 1);
      tick();
      iv3 = 1;
      drv_rand(0, 4'hB);
      @(negedge clk);
      chk("bub_in_ready_b", ir3, 1);
      tick();
      iv3 = 0;
      repeat (2) begin
         @(negedge clk);
         chk("bub_occupancy", oc3, 2);
         chk("bub_in_ready", ir3, 1);
         chk("bub_head", {r3, of3, ot3}, ea);
         tick();
      end
      or3 = 1;
      @(negedge clk);
      chk("bub_a_out", ov3, 1);
      tick();
      @(negedge clk);
      chk("bub_b_adjacent", ov3, 1);
      tick();
      @(negedge clk);
      chk("bub_empty", ov3, 0);
      tick();
      or3 = 0;
      iv3 = 1;
      for (int k = 0; k < 3; k++) begin
         drv_rand(1'(k), 4'(k + 12));
         tick();
      end
      iv3 = 0;
      @(negedge clk);
      chk("mid_occupancy", oc3, 3);
      tick();
      rst = 1;
      tick();
      rst = 0;
      @(negedge clk);
      chk("mid_out_valid", ov3, 0);
      chk("mid_occupancy0", oc3, 0);
      tick();
      or3 = 1;
      repeat (4) begin
         @(negedge clk);
         chk("mid_gone", ov3, 0);
         tick();
      end
      iv3 = 1;
      for (int k = 0; k < 14; k++) begin
         drv(sp[k][96], sp[k][95:64], sp[k][63:32], 4'(k), sp[k][31:0]);
         tick();
      end
      repeat (300) begin
         iv3 = $urandom_range(0, 3) != 0;
         or3 = $urandom_range(0, 3) != 0;
         drv_rand(1'($urandom_range(0, 1)), 4'($urandom));
         tick();
      end
      iv3 = 0;
      or3 = 1;
      repeat (6) tick();
      @(negedge clk);
      chk("sb_left", 64'(q3.size()), 64'(0));
      tick();
      for (int k = 0; k < 8; k++) begin
         or0 = k[0];
         iv0 = k[1];
         drv_rand(k[2], 4'(k + 3));
         @(negedge clk);
         chk("pd0_in_ready", ir0, or0);
         chk("pd0_out_valid", ov0, iv0);
         chk("pd0_r", r0, cur_exp[36:5]);
         chk("pd0_fmt", 64'(of0), 64'(cur_exp[4]));
         chk("pd0_tag", ot0, tag);
         chk("pd0_occ_busy", {oc0, bz0}, 0);
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
